// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage driving a word-wide req/ack bus,
// with byte-lane steering, two-beat misaligned accesses, load extension and bus timeout.
module load_store_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [3:0]            bus_wstrb,
    output logic [DATA_WIDTH-1:0] bus_wdata,
    input  logic                  bus_ack,
    input  logic [DATA_WIDTH-1:0] bus_rdata
);
    // GAP is the mandatory idle bus cycle between the two beats of a split access
    typedef enum logic [2:0] {IDLE, BEAT0, GAP, BEAT1, DONE} state_t;
    state_t                state_q, state_d;
    logic                  we_q, sign_q, err_q, err_d;
    logic [1:0]            size_q;
    logic [ADDR_WIDTH-1:0] addr_q, base0, base1;
    logic [DATA_WIDTH-1:0] wdata_q, b0_q, rdata_q, rdata_d, rsh, rext;
    logic [31:0]           cnt_q, cnt_d;
    logic [1:0]            off;
    logic                  split, beat, timeout;
    logic [3:0]            nmask;
    logic [7:0]            mask;
    logic [63:0]           wsh, rcat;
    assign off     = addr_q[1:0];
    assign split   = (size_q == 2'b01 && off == 2'd3) || (size_q[1] && off != 2'd0);
    assign nmask   = size_q == 2'b00 ? 4'b0001 : size_q == 2'b01 ? 4'b0011 : 4'b1111;
    assign mask    = {4'b0000, nmask} << off;
    assign wsh     = {32'b0, wdata_q} << {off, 3'b000};
    assign rcat    = state_q == BEAT1 ? {bus_rdata, b0_q} : {32'b0, bus_rdata};
    assign rsh     = 32'(rcat >> {off, 3'b000});
    assign rext    = size_q == 2'b00 ? {{24{sign_q & rsh[7]}}, rsh[7:0]} :
                     size_q == 2'b01 ? {{16{sign_q & rsh[15]}}, rsh[15:0]} : rsh;
    assign base0   = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign base1   = {addr_q[ADDR_WIDTH-1:2] + (ADDR_WIDTH-2)'(1), 2'b00};
    assign beat    = state_q == BEAT0 || state_q == BEAT1;
    assign timeout = TIMEOUT_CYCLES != 0 && cnt_q == 32'(TIMEOUT_CYCLES - 1);
    assign ready     = state_q == IDLE;
    assign done      = state_q == DONE;
    assign err       = done & err_q;
    assign rdata     = rdata_q;
    assign bus_req   = beat;
    assign bus_we    = beat & we_q;
    assign bus_addr  = state_q == BEAT0 ? base0 : state_q == BEAT1 ? base1 : '0;
    assign bus_wstrb = !we_q ? 4'b0000 : state_q == BEAT0 ? mask[3:0] : state_q == BEAT1 ? mask[7:4] : 4'b0000;
    assign bus_wdata = state_q == BEAT0 ? wsh[31:0] : state_q == BEAT1 ? wsh[63:32] : '0;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req) begin
                state_d = BEAT0;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            BEAT0, BEAT1: if (bus_ack) begin
                state_d = (state_q == BEAT0 && split) ? GAP : DONE;
                rdata_d = (!we_q && !(state_q == BEAT0 && split)) ? rext : rdata_q;
            end else if (timeout) begin
                state_d = DONE;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
            GAP: begin
                state_d = BEAT1;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            b0_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (ready && req) begin
                we_q    <= we;
                sign_q  <= sign;
                size_q  <= size;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == BEAT0 && bus_ack) b0_q <= bus_rdata;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a
// byte-addressed memory model and a behavioural bus slave.
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req = 1'b0, we = 1'b0, sign = 1'b0;
    logic [1:0]  size = 2'b00;
    logic [31:0] addr = '0, wdata = '0;
    logic        ready, done, err, bus_req, bus_we, bus_ack;
    logic [31:0] rdata, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign(sign),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
        .rdata(rdata), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata)
    );

    // Slave memory is word-addressed and only sees bus traffic; the model is byte-addressed
    logic [31:0] smem [logic [31:0]];
    logic [7:0]  bmem [logic [31:0]];
    logic [31:0] log_addr[$], log_wdata[$];
    logic [3:0]  log_strb[$];
    int          log_cyc[$];
    int ack_delay = 0, wcnt = 0, cyc = 0;
    logic [31:0] last_rd = '0;

    function automatic logic [31:0] sget(input logic [31:0] a);
        return smem.exists(a) ? smem[a] : 32'h0;
    endfunction
    function automatic logic [7:0] bget(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : 8'h00;
    endfunction
    function automatic logic [31:0] mword(input logic [31:0] a);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = bget(a + i);
        return v;
    endfunction
    function automatic int nbytes(input logic [1:0] sz);
        return sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
    endfunction
    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic s);
        logic [31:0] v = '0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = bget(a + i);
        if (n == 1 && s && v[7]) v[31:8] = '1;
        if (n == 2 && s && v[15]) v[31:16] = '1;
        return v;
    endfunction
    task automatic model_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < nbytes(sz); i++) bmem[a + i] = d[8*i +: 8];
    endtask
    task automatic set_word(input logic [31:0] a, input logic [31:0] v);
        smem[a] = v;
        for (int i = 0; i < 4; i++) bmem[a + i] = v[8*i +: 8];
    endtask

    initial begin
        logic [31:0] w;
        bus_ack = 1'b0;
        bus_rdata = '0;
        forever begin
            @(negedge clk);
            cyc++;
            bus_ack = 1'b0;
            if (bus_req) begin
                if (wcnt >= ack_delay) begin
                    wcnt = 0;
                    bus_ack = 1'b1;
                    w = sget(bus_addr);
                    bus_rdata = w;
                    if (bus_we) begin
                        for (int b = 0; b < 4; b++) if (bus_wstrb[b]) w[8*b +: 8] = bus_wdata[8*b +: 8];
                        smem[bus_addr] = w;
                    end
                    log_addr.push_back(bus_addr);
                    log_strb.push_back(bus_wstrb);
                    log_wdata.push_back(bus_wdata);
                    log_cyc.push_back(cyc);
                end else wcnt++;
            end else wcnt = 0;
        end
    end

    // Runs one access and watches 40 cycles; lat counts negedges after the accept edge
    task automatic access(input logic a_we, input logic [1:0] a_sz, input logic a_s,
                          input logic [31:0] a_addr, input logic [31:0] a_wd,
                          output int lat, output logic a_err, output logic [31:0] a_rd, output int pulses);
        log_addr.delete(); log_strb.delete(); log_wdata.delete(); log_cyc.delete();
        @(negedge clk);
        req = 1'b1; we = a_we; size = a_sz; sign = a_s; addr = a_addr; wdata = a_wd;
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'($urandom); size = 2'($urandom); sign = 1'($urandom);
        addr = $urandom; wdata = $urandom;
        lat = -1; pulses = 0; a_err = 1'bx; a_rd = 'x;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                if (lat < 0) begin lat = k; a_err = err; a_rd = rdata; end
                pulses++;
            end
        end
    endtask

    task automatic test_reset;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        checks++; if ({bus_req, bus_we, bus_wstrb} !== 6'b0) begin failures++; $display("FAIL reset_bus_ctl got=%b exp=0", {bus_req, bus_we, bus_wstrb}); end
        checks++; if ({bus_addr, bus_wdata} !== 64'h0) begin failures++; $display("FAIL reset_bus_data got=%h exp=0", {bus_addr, bus_wdata}); end
        last_rd = '0;
    endtask

    task automatic test_word_load;
        int lat, p; logic e; logic [31:0] rd;
        set_word(32'h100, 32'hDEADBEEF);
        ack_delay = 0;
        access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, e, rd, p);
        checks++; if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL word_load_rdata got=%h exp=deadbeef", rd); end
        checks++; if (lat !== 2 || p !== 1) begin failures++; $display("FAIL word_load_timing got lat=%0d pulses=%0d exp lat=2 pulses=1", lat, p); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL word_load_err got=%b exp=0", e); end
        checks++; if (log_addr.size() !== 1 || log_addr[0] !== 32'h100 || log_strb[0] !== 4'b0) begin failures++; $display("FAIL word_load_bus got beats=%0d addr=%h exp beats=1 addr=100", log_addr.size(), log_addr[0]); end
        last_rd = 32'hDEADBEEF;
    endtask

    task automatic test_byte_loads;
        int lat, p; logic e; logic [31:0] rd;
        set_word(32'h200, 32'h80FF_0000);
        access(1'b0, 2'b00, 1'b1, 32'h203, 32'h0, lat, e, rd, p);
        checks++; if (rd !== 32'hFFFFFF80) begin failures++; $display("FAIL byte_load_signed got=%h exp=ffffff80", rd); end
        access(1'b0, 2'b00, 1'b0, 32'h203, 32'h0, lat, e, rd, p);
        checks++; if (rd !== 32'h00000080) begin failures++; $display("FAIL byte_load_unsigned got=%h exp=00000080", rd); end
        last_rd = 32'h80;
    endtask

    task automatic test_half_store;
        int lat, p; logic e; logic [31:0] rd;
        model_store(32'h302, 2'b01, 32'h1234ABCD);
        access(1'b1, 2'b01, 1'b0, 32'h302, 32'h1234ABCD, lat, e, rd, p);
        checks++; if (log_addr.size() !== 1) begin failures++; $display("FAIL half_store_beats got=%0d exp=1", log_addr.size()); end
        checks++; if (log_strb[0] !== 4'b1100 || log_wdata[0][31:16] !== 16'hABCD) begin failures++; $display("FAIL half_store_lanes got strb=%b data=%h exp strb=1100 data=abcd____", log_strb[0], log_wdata[0]); end
        checks++; if (rd !== last_rd) begin failures++; $display("FAIL half_store_rdata_kept got=%h exp=%h", rd, last_rd); end
        checks++; if (sget(32'h300) !== mword(32'h300)) begin failures++; $display("FAIL half_store_mem got=%h exp=%h", sget(32'h300), mword(32'h300)); end
    endtask

    task automatic test_split_store;
        int lat, p; logic e; logic [31:0] rd;
        model_store(32'h401, 2'b10, 32'hAABBCCDD);
        access(1'b1, 2'b10, 1'b0, 32'h401, 32'hAABBCCDD, lat, e, rd, p);
        checks++; if (log_addr.size() !== 2) begin failures++; $display("FAIL split_store_beats got=%0d exp=2", log_addr.size()); end
        else begin
            checks++; if (log_addr[0] !== 32'h400 || log_strb[0] !== 4'b1110 || log_wdata[0][31:8] !== 24'hBBCCDD) begin failures++; $display("FAIL split_store_beat0 got addr=%h strb=%b data=%h", log_addr[0], log_strb[0], log_wdata[0]); end
            checks++; if (log_addr[1] !== 32'h404 || log_strb[1] !== 4'b0001 || log_wdata[1][7:0] !== 8'hAA) begin failures++; $display("FAIL split_store_beat1 got addr=%h strb=%b data=%h", log_addr[1], log_strb[1], log_wdata[1]); end
            checks++; if (log_cyc[1] - log_cyc[0] !== 2) begin failures++; $display("FAIL split_store_gap got=%0d exp=2", log_cyc[1] - log_cyc[0]); end
        end
        checks++; if (lat !== 4 || p !== 1 || e !== 1'b0) begin failures++; $display("FAIL split_store_done got lat=%0d pulses=%0d err=%b exp 4 1 0", lat, p, e); end
        checks++; if (sget(32'h400) !== mword(32'h400) || sget(32'h404) !== mword(32'h404)) begin failures++; $display("FAIL split_store_mem got=%h_%h exp=%h_%h", sget(32'h404), sget(32'h400), mword(32'h404), mword(32'h400)); end
    endtask

    task automatic test_split_load_wrap;
        int lat, p; logic e; logic [31:0] rd;
        set_word(32'h5FC, 32'h11345678); set_word(32'h600, 32'h9ABCDE22);
        access(1'b0, 2'b01, 1'b0, 32'h5FF, 32'h0, lat, e, rd, p);
        checks++; if (rd !== 32'h00002211 || lat !== 4) begin failures++; $display("FAIL split_half_load got rdata=%h lat=%0d exp 00002211 4", rd, lat); end
        set_word(32'hFFFFFFFC, 32'h11AAAAAA); set_word(32'h0, 32'h55555522);
        access(1'b0, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h0, lat, e, rd, p);
        checks++; if (rd !== 32'h00002211) begin failures++; $display("FAIL wrap_half_load got=%h exp=00002211", rd); end
        checks++; if (log_addr.size() !== 2 || log_addr[1] !== 32'h0) begin failures++; $display("FAIL wrap_beat1_addr got beats=%0d addr=%h exp 2 00000000", log_addr.size(), log_addr[1]); end
        last_rd = 32'h2211;
    endtask

    task automatic test_timeout;
        int lat, p; logic e; logic [31:0] rd;
        ack_delay = 1000;
        access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, e, rd, p);
        checks++; if (lat !== 5 || p !== 1 || e !== 1'b1) begin failures++; $display("FAIL timeout_done got lat=%0d pulses=%0d err=%b exp 5 1 1", lat, p, e); end
        checks++; if (rd !== last_rd) begin failures++; $display("FAIL timeout_rdata got=%h exp=%h", rd, last_rd); end
        checks++; if (log_addr.size() !== 0) begin failures++; $display("FAIL timeout_beats got=%0d exp=0", log_addr.size()); end
        ack_delay = 3;
        access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, e, rd, p);
        checks++; if (lat !== 5 || e !== 1'b0 || rd !== 32'hDEADBEEF) begin failures++; $display("FAIL ack_at_limit got lat=%0d err=%b rdata=%h exp 5 0 deadbeef", lat, e, rd); end
        last_rd = 32'hDEADBEEF;
        ack_delay = 0;
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        ack_delay = 1000;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h100;
        @(posedge clk);
        #1 req = 1'b0;
        @(negedge clk);
        checks++; if (bus_req !== 1'b1) begin failures++; $display("FAIL mid_bus_req got=%b exp=1", bus_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus_req !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL async_reset got bus_req=%b ready=%b exp 0 1", bus_req, ready); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL async_reset_rdata got=%h exp=0", rdata); end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (done) pulses++; end
        checks++; if (pulses !== 0) begin failures++; $display("FAIL reset_discard got pulses=%0d exp=0", pulses); end
        last_rd = '0;
        ack_delay = 0;
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; sign = 1'b0; addr = 32'h100;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (k == 11) req = 1'b0;
            @(negedge clk);
            if (done) pulses++;
        end
        for (int k = 0; k < 6; k++) begin @(negedge clk); if (done) pulses++; end
        checks++; if (pulses !== 4) begin failures++; $display("FAIL back_to_back_pulses got=%0d exp=4", pulses); end
        checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL back_to_back_rdata got=%h exp=deadbeef", rdata); end
        last_rd = 32'hDEADBEEF;
    endtask

    task automatic test_random;
        int lat, p, d, n, off, exp_lat;
        logic e, w, s, sp;
        logic [1:0] sz;
        logic [31:0] a, wd, rd, exp_rd, wa;
        for (int t = 0; t < 150; t++) begin
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + $urandom_range(0, 15) : 32'h1000 + $urandom_range(0, 63);
            sz = 2'($urandom_range(0, 3)); s = 1'($urandom); w = 1'($urandom); wd = $urandom;
            d  = $urandom_range(0, 3);
            n  = nbytes(sz); off = int'(a[1:0]); sp = (off + n > 4);
            exp_lat = sp ? 4 + 2 * d : 2 + d;
            ack_delay = d;
            exp_rd = w ? last_rd : model_load(a, sz, s);
            if (w) model_store(a, sz, wd);
            access(w, sz, s, a, wd, lat, e, rd, p);
            checks++; if (lat !== exp_lat || p !== 1 || e !== 1'b0) begin failures++; $display("FAIL rand_done t=%0d got lat=%0d pulses=%0d err=%b exp %0d 1 0", t, lat, p, e, exp_lat); end
            checks++; if (rd !== exp_rd) begin failures++; $display("FAIL rand_rdata t=%0d a=%h sz=%0d we=%b got=%h exp=%h", t, a, sz, w, rd, exp_rd); end
            checks++; if (log_addr.size() !== (sp ? 2 : 1) || log_addr[0] !== {a[31:2], 2'b00}) begin failures++; $display("FAIL rand_beats t=%0d got n=%0d addr=%h exp n=%0d addr=%h", t, log_addr.size(), log_addr[0], sp ? 2 : 1, {a[31:2], 2'b00}); end
            for (int b = 0; b < (sp ? 2 : 1); b++) begin
                wa = {a[31:2], 2'b00} + 32'(4 * b);
                checks++;
                if (w ? (sget(wa) !== mword(wa)) : (log_strb.size() > b && log_strb[b] !== 4'b0)) begin
                    failures++; $display("FAIL rand_mem t=%0d word=%h got=%h exp=%h", t, wa, sget(wa), mword(wa));
                end
            end
            last_rd = exp_rd;
        end
        ack_delay = 0;
    endtask

    initial begin
        #12 rst = 1'b0;
        @(negedge clk);
        test_reset;
        test_word_load;
        test_byte_loads;
        test_half_store;
        test_split_store;
        test_split_load_wrap;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
